// File: rtl/r16_pkg.sv
// Shared constants and types for the radix-16 NTT write-back path.
// D_width is the common per-lane index width (bank address / bank number).
`ifndef D_width
`define D_width 8
`endif

package r16_pkg;

   localparam int LANES  = 16;
   localparam int BANK_W = 4;
   localparam int D_W    = `D_width;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } wb_state_e;

   typedef logic [LANES-1:0][D_W-1:0]    idx_vec_t;
   typedef logic [LANES-1:0][BANK_W-1:0] bank_lane_t;
   typedef logic [LANES-1:0][63:0]       lane_data64_t;

endpackage

// File: rtl/r16_bank_xbar.sv
// Combinational 16x16 priority crossbar: per bank, the lowest lane naming it wins.
// any_conflict_o flags a bank claimed by two or more lanes.
module r16_bank_xbar
   import r16_pkg::*;
(
   input  bank_lane_t        bank_i,
   output bank_lane_t        sel_o,
   output logic [LANES-1:0]  hit_o,
   output logic              any_conflict_o
);

   always_comb begin
      sel_o          = '0;
      hit_o          = '0;
      any_conflict_o = 1'b0;
      // Ascending lane scan: the first match claims the bank, later matches are dropped.
      for (int b = 0; b < LANES; b++) begin
         for (int i = 0; i < LANES; i++) begin
            if (bank_i[i] == BANK_W'(b)) begin
               if (hit_o[b]) begin
                  any_conflict_o = 1'b1;
               end else begin
                  hit_o[b] = 1'b1;
                  sel_o[b] = BANK_W'(i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/r16_bank_writeback.sv
// Write-back stage: routes 16 butterfly lanes to 16 banks, registers the bank writes,
// counts groups/stages and pulses stage/NTT completion alongside the final group's writes.
module r16_bank_writeback
   import r16_pkg::*;
#(
   parameter int GROUPS = 256,
   parameter int STAGES = 3,
   parameter int DATA_W = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          in_valid,
   input  idx_vec_t                      ma_idx,
   input  idx_vec_t                      bn_idx,
   input  logic [LANES-1:0][DATA_W-1:0]  lane_data,
   output logic [LANES-1:0]              wr_en,
   output idx_vec_t                      wr_addr,
   output logic [LANES-1:0][DATA_W-1:0]  wr_data,
   output logic                          busy,
   output logic                          stage_done,
   output logic                          ntt_done,
   output logic                          conflict_err,
   output logic                          proto_err
);

   localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

   wb_state_e                   state_q, state_d;
   logic [GRP_W-1:0]            grp_cnt_q, grp_cnt_d;
   logic [STG_W-1:0]            stg_cnt_q, stg_cnt_d;
   logic [LANES-1:0]            wr_en_d;
   idx_vec_t                    wr_addr_d;
   logic [LANES-1:0][DATA_W-1:0] wr_data_d;
   logic                        busy_d, stage_done_d, ntt_done_d, conflict_d, proto_d;

   bank_lane_t       bank_of_lane, sel;
   logic [LANES-1:0] hit;
   logic             any_conflict, accept, last_grp, last_stg, unused_bn;

   // Only the low BANK_W bits of each bank number select a bank.
   always_comb begin
      for (int i = 0; i < LANES; i++) bank_of_lane[i] = bn_idx[i][BANK_W-1:0];
   end
   assign unused_bn = ^bn_idx;

   r16_bank_xbar u_xbar (
      .bank_i         (bank_of_lane),
      .sel_o          (sel),
      .hit_o          (hit),
      .any_conflict_o (any_conflict)
   );

   assign accept   = in_valid && (state_q == RUN);
   assign last_grp = (grp_cnt_q == GRP_W'(GROUPS - 1));
   assign last_stg = (stg_cnt_q == STG_W'(STAGES - 1));

   always_comb begin
      state_d      = state_q;
      grp_cnt_d    = grp_cnt_q;
      stg_cnt_d    = stg_cnt_q;
      conflict_d   = conflict_err;
      proto_d      = proto_err;
      stage_done_d = accept && last_grp;
      ntt_done_d   = accept && last_grp && last_stg;
      wr_en_d      = accept ? hit : '0;
      wr_addr_d    = wr_addr;
      wr_data_d    = wr_data;

      if (state_q == IDLE && start) begin
         state_d    = RUN;
         grp_cnt_d  = '0;
         stg_cnt_d  = '0;
         conflict_d = 1'b0;
         proto_d    = 1'b0;
      end
      if (accept) begin
         if (any_conflict) conflict_d = 1'b1;
         if (last_grp) begin
            grp_cnt_d = '0;
            stg_cnt_d = last_stg ? '0 : stg_cnt_q + 1'b1;
            if (last_stg) state_d = IDLE;
         end else begin
            grp_cnt_d = grp_cnt_q + 1'b1;
         end
      end
      // A group arriving while idle (including the start cycle) is a protocol error.
      if (in_valid && state_q == IDLE) proto_d = 1'b1;

      for (int b = 0; b < LANES; b++) begin
         if (accept && hit[b]) begin
            wr_addr_d[b] = ma_idx[sel[b]];
            wr_data_d[b] = lane_data[sel[b]];
         end
      end
      // busy covers the ntt_done cycle even though the FSM is already back in IDLE.
      busy_d = (state_d == RUN) || ntt_done_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grp_cnt_q    <= '0;
         stg_cnt_q    <= '0;
         wr_en        <= '0;
         wr_addr      <= '0;
         wr_data      <= '0;
         busy         <= 1'b0;
         stage_done   <= 1'b0;
         ntt_done     <= 1'b0;
         conflict_err <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grp_cnt_q    <= grp_cnt_d;
         stg_cnt_q    <= stg_cnt_d;
         wr_en        <= wr_en_d;
         wr_addr      <= wr_addr_d;
         wr_data      <= wr_data_d;
         busy         <= busy_d;
         stage_done   <= stage_done_d;
         ntt_done     <= ntt_done_d;
         conflict_err <= conflict_d;
         proto_err    <= proto_d;
      end
   end

endmodule

// File: tb/tb_r16_bank_writeback.sv
// Directed bench for r16_bank_writeback with GROUPS=4, STAGES=2.
module tb_r16_bank_writeback;
   import r16_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n, start, in_valid;
   idx_vec_t           ma_idx, bn_idx, wr_addr;
   lane_data64_t       lane_data, wr_data;
   logic [LANES-1:0]   wr_en;
   logic               busy, stage_done, ntt_done, conflict_err, proto_err;

   int total = 0;
   int bad   = 0;

   idx_vec_t     exp_addr;
   lane_data64_t exp_data;
   int           cmap [16] = '{0, 1, 4, 3, 2, 5, 6, 7, 8, 4, 10, 9, 12, 13, 14, 15};

   always #5 clk = ~clk;

   r16_bank_writeback #(.GROUPS(4), .STAGES(2), .DATA_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .ma_idx       (ma_idx),
      .bn_idx       (bn_idx),
      .lane_data    (lane_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .stage_done   (stage_done),
      .ntt_done     (ntt_done),
      .conflict_err (conflict_err),
      .proto_err    (proto_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: identity, 1: rotate by 3, 2: lanes 2 and 9 collide on bank 4, bank 11 unused
   task automatic load(input int mode);
      for (int i = 0; i < 16; i++) begin
         case (mode)
            0: begin bn_idx[i] = D_W'(i);            ma_idx[i] = D_W'(5);      lane_data[i] = 64'(i + 100); end
            1: begin bn_idx[i] = D_W'((i + 3) % 16); ma_idx[i] = D_W'(i + 10); lane_data[i] = 64'(i + 200); end
            default: begin bn_idx[i] = D_W'(cmap[i]); ma_idx[i] = D_W'(i + 40); lane_data[i] = 64'(i + 300); end
         endcase
      end
   endtask

   task automatic send(input int mode);
      load(mode);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      ma_idx = '0; bn_idx = '0; lane_data = '0;
      step();
      total++;
      if ({wr_en, busy, stage_done, ntt_done, conflict_err, proto_err} !== 21'd0) begin
         bad++; $display("FAIL reset_ctrl got=%h exp=0", {wr_en, busy, stage_done, ntt_done, conflict_err, proto_err});
      end
      total++;
      if (wr_addr !== '0 || wr_data !== '0) begin
         bad++; $display("FAIL reset_addr_data got addr=%h data=%h exp=0", wr_addr, wr_data);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_proto();
      send(0);
      total++;
      if (wr_en !== 16'h0) begin bad++; $display("FAIL proto_wr_en got=%h exp=0", wr_en); end
      total++;
      if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_err_set got=%b exp=1", proto_err); end
      do_start();
      total++;
      if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_err_clear got=%b exp=0", proto_err); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b exp=1", busy); end
   endtask

   task automatic test_identity();
      send(0);
      for (int b = 0; b < 16; b++) begin exp_addr[b] = D_W'(5); exp_data[b] = 64'(b + 100); end
      total++;
      if (wr_en !== 16'hFFFF) begin bad++; $display("FAIL ident_en got=%h exp=ffff", wr_en); end
      total++;
      if (wr_addr !== exp_addr) begin bad++; $display("FAIL ident_addr got=%h exp=%h", wr_addr, exp_addr); end
      total++;
      if (wr_data !== exp_data) begin bad++; $display("FAIL ident_data got=%h exp=%h", wr_data, exp_data); end
      step();
      total++;
      if (wr_en !== 16'h0) begin bad++; $display("FAIL ident_one_cycle got=%h exp=0", wr_en); end
   endtask

   task automatic test_rotation();
      send(1);
      for (int i = 0; i < 16; i++) begin
         exp_addr[(i + 3) % 16] = D_W'(i + 10);
         exp_data[(i + 3) % 16] = 64'(i + 200);
      end
      total++;
      if (wr_en !== 16'hFFFF) begin bad++; $display("FAIL rot_en got=%h exp=ffff", wr_en); end
      total++;
      if (wr_addr !== exp_addr) begin bad++; $display("FAIL rot_addr got=%h exp=%h", wr_addr, exp_addr); end
      total++;
      if (wr_data !== exp_data) begin bad++; $display("FAIL rot_data got=%h exp=%h", wr_data, exp_data); end
      total++;
      if (conflict_err !== 1'b0) begin bad++; $display("FAIL rot_conflict got=%b exp=0", conflict_err); end
   endtask

   task automatic test_conflict();
      send(2);
      // bank 11 keeps the rotation write (lane 8): addr 18, data 208
      for (int b = 0; b < 16; b++) begin exp_addr[b] = D_W'(b + 40); exp_data[b] = 64'(b + 300); end
      exp_addr[4]  = D_W'(42); exp_data[4]  = 64'(302);
      exp_addr[2]  = D_W'(44); exp_data[2]  = 64'(304);
      exp_addr[9]  = D_W'(51); exp_data[9]  = 64'(311);
      exp_addr[11] = D_W'(18); exp_data[11] = 64'(208);
      total++;
      if (wr_en !== 16'hF7FF) begin bad++; $display("FAIL conf_en got=%h exp=f7ff", wr_en); end
      total++;
      if (wr_addr !== exp_addr) begin bad++; $display("FAIL conf_addr got=%h exp=%h", wr_addr, exp_addr); end
      total++;
      if (wr_data !== exp_data) begin bad++; $display("FAIL conf_data got=%h exp=%h", wr_data, exp_data); end
      total++;
      if (conflict_err !== 1'b1) begin bad++; $display("FAIL conf_err_set got=%b exp=1", conflict_err); end
      step();
      total++;
      if (conflict_err !== 1'b1) begin bad++; $display("FAIL conf_err_sticky got=%b exp=1", conflict_err); end
   endtask

   task automatic run_groups(input int first, input int last, input string tag);
      for (int g = first; g <= last; g++) begin
         load(0);
         in_valid = 1'b1;
         step();
         total++;
         if (stage_done !== (g % 4 == 0)) begin
            bad++; $display("FAIL %s_stage_done g=%0d got=%b exp=%b", tag, g, stage_done, (g % 4 == 0));
         end
         total++;
         if (ntt_done !== (g == 8)) begin
            bad++; $display("FAIL %s_ntt_done g=%0d got=%b exp=%b", tag, g, ntt_done, (g == 8));
         end
         total++;
         if (busy !== 1'b1 || wr_en !== 16'hFFFF) begin
            bad++; $display("FAIL %s_busy_en g=%0d got=%b/%h exp=1/ffff", tag, g, busy, wr_en);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      do_start();
      load(2);
      in_valid = 1'b1;
      step(); step(); step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if ({wr_en, busy, stage_done, ntt_done, conflict_err, proto_err} !== 21'd0) begin
         bad++; $display("FAIL midrst_ctrl got=%h exp=0", {wr_en, busy, stage_done, ntt_done, conflict_err, proto_err});
      end
      total++;
      if (wr_addr !== '0 || wr_data !== '0) begin
         bad++; $display("FAIL midrst_addr_data got addr=%h data=%h exp=0", wr_addr, wr_data);
      end
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_count();
      do_start();
      run_groups(1, 8, "count");
      step();
      total++;
      if (busy !== 1'b0 || ntt_done !== 1'b0 || stage_done !== 1'b0) begin
         bad++; $display("FAIL count_after got busy/stg/ntt=%b%b%b exp=000", busy, stage_done, ntt_done);
      end
   endtask

   task automatic test_start_ignored();
      do_start();
      run_groups(1, 2, "ign");
      do_start();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
      run_groups(3, 8, "ign");
      step();
      total++;
      if (busy !== 1'b0 || proto_err !== 1'b0) begin
         bad++; $display("FAIL ign_after got busy/proto=%b%b exp=00", busy, proto_err);
      end
   endtask

   task automatic test_start_with_valid();
      load(0);
      start = 1'b1;
      in_valid = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b0;
      total++;
      if (proto_err !== 1'b1 || wr_en !== 16'h0 || busy !== 1'b1) begin
         bad++; $display("FAIL start_valid got proto/en/busy=%b/%h/%b exp=1/0000/1", proto_err, wr_en, busy);
      end
   endtask

   initial begin
      test_reset();
      test_proto();
      test_identity();
      test_rotation();
      test_conflict();
      test_reset_mid_run();
      test_count();
      test_start_ignored();
      test_start_with_valid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/r16_bank_writeback.md
# r16_bank_writeback

Write-back end of the radix-16 NTT index pipeline. Takes the 12-cycle-delayed per-lane memory-address (MA) and bank-number (BN) indices, the delayed enable, and the 16 butterfly result lanes. Routes each lane to its bank through a crossbar, issues registered bank writes, counts groups and stages, and pulses stage/NTT completion. Sits between the radix-16 butterfly output and the 16 single-port coefficient banks.

## Interface
- `GROUPS`, default 256: radix-16 groups per stage (N/16); ≥1.
- `STAGES`, default 3: stages per NTT; ≥1.
- `DATA_W`, default 64: coefficient width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that arms a new NTT.
- `in_valid` in 1: delayed enable; one group is presented this cycle.
- `ma_idx` in 16×`D_width`: per-lane bank address (delayed MA0..MA15).
- `bn_idx` in 16×`D_width`: per-lane bank number (delayed BN0..BN15); only bits [3:0] used.
- `lane_data` in 16×DATA_W: butterfly results, lane-aligned with indices.
- `wr_en` out 16: per-bank write enable.
- `wr_addr` out 16×`D_width`: per-bank write address.
- `wr_data` out 16×DATA_W: per-bank write data.
- `busy` out 1: high in RUN.
- `stage_done` out 1: one-cycle pulse, last group of a stage written.
- `ntt_done` out 1: one-cycle pulse, last group of last stage written.
- `conflict_err` out 1: sticky, two lanes targeted one bank.
- `proto_err` out 1: sticky, `in_valid` seen outside RUN.

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on `start`; this clears the group/stage counters and both error flags.
  - RUN→IDLE in the cycle `ntt_done` is asserted.
  - `start` in RUN is ignored, with no counter or flag effect.
- Crossbar, when `in_valid` in RUN: for bank b, select the lowest lane i with `bn_idx[i][3:0]==b`. Then `wr_en[b]`=1, `wr_addr[b]`=`ma_idx[i]`, `wr_data[b]`=`lane_data[i]`. Banks with no match get `wr_en[b]`=0, with addr/data held.
- Conflict: if any bank matches more than one lane, the lowest lane wins, the other lanes are dropped, and `conflict_err` sets.
- Counters:
  - `grp_cnt` (0..GROUPS-1) increments per accepted group.
  - At GROUPS-1 it wraps to 0, `stg_cnt` increments, and `stage_done` pulses.
  - At `stg_cnt`==STAGES-1 with `grp_cnt`==GROUPS-1, `ntt_done` pulses too, in the same cycle as `stage_done`.
- `in_valid` in IDLE: no writes, counters unchanged, `proto_err` sets.
- Reset (any time, including mid-RUN): state IDLE, counters 0. All outputs 0: `wr_en`, `wr_addr`, `wr_data`, `busy`, `stage_done`, `ntt_done`, both error flags. Partial NTT is discarded.

## Timing
- All outputs registered.
- `in_valid` at edge t produces `wr_en`/`wr_addr`/`wr_data` valid in cycle t+1, for one cycle only.
- `stage_done`/`ntt_done` are high in the same cycle as the writes of the final group.
- `busy` rises the cycle after `start` and falls the cycle after `ntt_done`.
- Back-to-back `in_valid` is supported at 1 group/cycle with no bubbles.
- `start` in the same cycle as `ntt_done`'s registering edge is ignored, because the FSM is still in RUN.
- `in_valid` in the cycle the `start` edge is sampled is a protocol error (state still IDLE).

## Structure
- Shared package `r16_pkg`: `LANES`=16, `BANK_W`=4, state enum `wb_state_e` {IDLE, RUN}, packed lane-array typedefs for index and data vectors. `D_width` comes from the common define header.
- Sub-module `r16_bank_xbar`: combinational 16×16 priority crossbar plus conflict detect. Outputs are per-bank select/hit and `any_conflict`.
- Top holds the FSM, counters and output registers.

## Test plan
- Identity map: `bn_idx[i]`=i, `ma_idx[i]`=5, data=i+100, one `in_valid` → cycle+1: `wr_en`=16'hFFFF, all addr 5, bank i data i+100.
- Rotation: `bn_idx[i]`=(i+3)%16 → bank (i+3)%16 receives lane i data, with its `ma_idx`. `conflict_err`=0.
- Conflict: lanes 2 and 9 → bank 4, lanes 0..15 otherwise distinct except bank 11 unused → bank 4 gets lane 2, `wr_en[11]`=0, `conflict_err`=1 until next `start`.
- Count: GROUPS=4, STAGES=2, eight back-to-back `in_valid`.
  - `stage_done` on the 4th and 8th write cycles.
  - `ntt_done` on the 8th only.
  - `busy` low the next cycle.
- Protocol: `in_valid` in IDLE → no `wr_en`, `proto_err`=1. A following `start` clears it to 0.
- Reset mid-RUN: after 3 of 8 groups, pulse `rst_n` low → all outputs 0 immediately. After restart, 8 groups give `ntt_done` on the 8th, not the 5th.
